icache_fetch: RTL and testbench
===============================

// Module: icache_fetch
// PURPOSE
// Direct-mapped, one-word-per-line instruction cache between the IF stage and memCtrl.
// Serves IF fetch requests in one cycle on hit. On a miss it drives memCtrl's IF port.
// It holds that request until memCtrl returns the 32-bit instruction, then fills the line and answers IF.
// Removes repeated 4-byte RAM fetches for loops and straight-line re-execution.
// PARAMETERS
// INDEX_BITS  7   log2(number of lines); line = one 32-bit instruction word
// ADDR_W      32  address width; tag = addr[ADDR_W-1:INDEX_BITS+2]
// PORTS
// clk_in        in   1       clock; all state updates on rising edge
// rst_in        in   1       reset, asynchronous, active-high
// IFreq_in      in   1       IF requests instruction at IFaddr_in this cycle
// IFaddr_in     in   ADDR_W  fetch address; [1:0] ignored (word aligned)
// flush_in      in   1       jump/branch redirect: abort outstanding request
// IFinstE_out   out  1       one-cycle pulse: IFinst_out valid
// IFinst_out    out  32      returned instruction
// busy_out      out  1       high while a miss is outstanding (state MISS)
// memReq_out    out  1       to memCtrl IF_in: fetch request
// memAddr_out   out  ADDR_W  to memCtrl IFAddr_in: {addr[ADDR_W-1:2],2'b00}
// memInstE_in   in   1       from memCtrl IFinstE_out: fetched word valid
// memInst_in    in   32      from memCtrl IFinst_out
// BEHAVIOUR
// - Reset (async, rst_in=1): all valid bits 0, state IDLE.
//   IFinstE_out=0, IFinst_out=0, busy_out=0, memReq_out=0, memAddr_out=0.
//   Tag/data arrays are not reset.
// - index = addr[INDEX_BITS+1:2]. hit = valid[index] && tag[index]==addr tag.
// - States: IDLE, MISS. Outputs registered; IFinstE_out defaults to 0 every cycle.
// - IDLE, IFreq_in=1, flush_in=0, hit: next cycle IFinstE_out=1, IFinst_out=data[index]; stay IDLE.
//   Hit latency 1 cycle. Back-to-back hits give one per cycle.
// - IDLE, IFreq_in=1, flush_in=0, miss: capture the address. Next cycle memReq_out=1,
//   memAddr_out=aligned address, busy_out=1; go to MISS.
// - IDLE, each cycle with IFreq_in=1 is a new request. IF must drop or change the request on the pulse cycle.
// - MISS: memReq_out and memAddr_out are held stable. IFreq_in and IFaddr_in are ignored.
//   memCtrl may stall this port for MEM traffic; no timeout.
// - MISS, memInstE_in=1, flush_in=0: write data/tag, set valid[index]. Next cycle:
//   IFinstE_out=1, IFinst_out=memInst_in, memReq_out=0, busy_out=0, state IDLE.
//   memReq_out must drop there so memCtrl restarts its counter.
// - flush_in=1 (any state) has priority over every other input in that cycle.
//   Next cycle: memReq_out=0, busy_out=0, IFinstE_out=0, state IDLE.
//   A memInstE_in in the same cycle is discarded: no array write, no pulse.
//   A request in the same cycle is dropped.
// - memInstE_in while IDLE is ignored (late data after abort).
// - Replacement: a miss overwrites the line unconditionally (direct-mapped).
// - Reset mid-miss: immediate abort as above. Cache returns fully invalid.
// TESTING
// 1. Reset, then IFreq_in at 0x00000000. Bench memCtrl returns 0x00000013 after 5 cycles.
//    -> memReq_out=1 with memAddr_out=0x0 from the cycle after the request until the return.
//    -> IFinstE_out pulse, IFinst_out=0x00000013, memReq_out=0 the next cycle.
// 2. Re-request 0x00000000 -> IFinstE_out=1 one cycle later with 0x00000013; memReq_out stays 0.
// 3. INDEX_BITS=7, fill 0x00000000, then request 0x00000200 (same index 0) with 0x00100093 returned.
//    -> miss and refill. A later request to 0x00000000 misses again.
// 4. Flush two cycles into a miss on 0x00000004, memInstE_in arriving same cycle as flush_in.
//    -> no pulse, memReq_out=0 next cycle. Re-request of 0x00000004 misses (line not written).
// 5. Hits on 0x0,0x4,0x8 in consecutive cycles after warming -> three consecutive one-cycle pulses, correct data each.
// 6. Assert rst_in asynchronously mid-miss -> outputs zero without clock edge. Prior hit address misses afterward.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache, one 32-bit word per line, sitting between
// the IF stage and the memCtrl IF port. Hits answer one cycle after the
// request. Misses hold a request on memCtrl until the word comes back, then
// fill the line and answer IF.
module icache_fetch #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              IFreq_in,
    input  logic [ADDR_W-1:0] IFaddr_in,
    input  logic              flush_in,
    output logic              IFinstE_out,
    output logic [31:0]       IFinst_out,
    output logic              busy_out,
    output logic              memReq_out,
    output logic [ADDR_W-1:0] memAddr_out,
    input  logic              memInstE_in,
    input  logic [31:0]       memInst_in
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MISS = 1'b1;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Tag and data arrays carry no reset; the valid bits alone decide a hit.
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [0:0]        state_q,     state_d;
    logic [LINES-1:0]  valid_q,     valid_d;
    logic              inst_e_q,    inst_e_d;
    logic [31:0]       inst_q,      inst_d;
    logic              busy_q,      busy_d;
    logic              mem_req_q,   mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              fill_we;

    logic [ADDR_W-1:0]     req_addr_aligned;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic                  req_hit;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_W-1:0]      fill_tag;

    // Address split for the incoming request and for the outstanding miss.
    always_comb begin
        req_addr_aligned = IFaddr_in & WORD_MASK;
        req_index        = req_addr_aligned[INDEX_BITS+1:2];
        req_tag          = req_addr_aligned[ADDR_W-1:INDEX_BITS+2];
        req_hit          = valid_q[req_index] && (tag_mem[req_index] == req_tag);
        fill_index       = mem_addr_q[INDEX_BITS+1:2];
        fill_tag         = mem_addr_q[ADDR_W-1:INDEX_BITS+2];
    end

    // Next-state logic; a flush overrides every other input of its cycle.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        inst_e_d   = 1'b0;
        inst_d     = inst_q;
        busy_d     = busy_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fill_we    = 1'b0;

        if (flush_in) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            mem_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IFreq_in) begin
                        if (req_hit) begin
                            inst_e_d = 1'b1;
                            inst_d   = data_mem[req_index];
                        end else begin
                            state_d    = ST_MISS;
                            busy_d     = 1'b1;
                            mem_req_d  = 1'b1;
                            mem_addr_d = req_addr_aligned;
                        end
                    end
                end
                ST_MISS: begin
                    // memReq/memAddr hold until the word returns; no timeout.
                    if (memInstE_in) begin
                        fill_we             = 1'b1;
                        valid_d[fill_index] = 1'b1;
                        inst_e_d            = 1'b1;
                        inst_d              = memInst_in;
                        busy_d              = 1'b0;
                        mem_req_d           = 1'b0;
                        state_d             = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            inst_e_q   <= 1'b0;
            inst_q     <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            inst_e_q   <= inst_e_d;
            inst_q     <= inst_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Line fill on memCtrl return; overwrites whatever the line held.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= memInst_in;
        end
    end

    assign IFinstE_out = inst_e_q;
    assign IFinst_out  = inst_q;
    assign busy_out    = busy_q;
    assign memReq_out  = mem_req_q;
    assign memAddr_out = mem_addr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: a memCtrl responder, a reference cache model kept as
// valid/tag tables over a fixed backing memory, and a scoreboard monitor that
// checks every IFinstE_out pulse against the queued expected instruction.
module tb_icache_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        IFreq_in;
    logic [31:0] IFaddr_in;
    logic        flush_in;
    logic        IFinstE_out;
    logic [31:0] IFinst_out;
    logic        busy_out;
    logic        memReq_out;
    logic [31:0] memAddr_out;
    logic        memInstE_in;
    logic [31:0] memInst_in;

    // memCtrl side is driven by the responder or, for directed cases, by hand.
    logic        resp_e = 1'b0;
    logic [31:0] resp_data = '0;
    logic        man_e = 1'b0;
    logic [31:0] man_data = '0;
    logic        resp_en = 1'b1;
    int          mem_lat = 5;

    assign memInstE_in = resp_e | man_e;
    assign memInst_in  = man_e ? man_data : resp_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];

    // Reference model: 128 lines, index = addr[8:2], tag = addr[31:9].
    bit          mv [128];
    logic [22:0] mt [128];

    icache_fetch dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .IFreq_in    (IFreq_in),
        .IFaddr_in   (IFaddr_in),
        .flush_in    (flush_in),
        .IFinstE_out (IFinstE_out),
        .IFinst_out  (IFinst_out),
        .busy_out    (busy_out),
        .memReq_out  (memReq_out),
        .memAddr_out (memAddr_out),
        .memInstE_in (memInstE_in),
        .memInst_in  (memInst_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)   return 32'h00000013;
        if (a == 32'h200) return 32'h00100093;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[8:2]] && (mt[a[8:2]] == a[31:9]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected word.
    always @(negedge clk_in) begin
        if (!rst_in && IFinstE_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                chk("inst_data", IFinst_out, exp_q.pop_front());
            end
        end
    end

    // memCtrl responder: answers an outstanding request after mem_lat cycles.
    initial begin
        forever begin
            @(negedge clk_in);
            if (resp_en && memReq_out && !rst_in) begin
                for (int k = 1; k < mem_lat && memReq_out; k++) @(negedge clk_in);
                if (resp_en && memReq_out && !rst_in) begin
                    resp_data = mem_word(memAddr_out);
                    resp_e    = 1'b1;
                    @(negedge clk_in);
                    resp_e    = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One fetch through the cache, classified as hit or miss by the model.
    task automatic fetch(input logic [31:0] addr);
        logic [31:0] al;
        bit          hit;
        bit          hold_ok;
        int          n;
        al  = addr & 32'hFFFF_FFFC;
        hit = model_hit(al);
        exp_q.push_back(mem_word(al));
        step();
        IFreq_in  = 1'b1;
        IFaddr_in = addr;
        step();
        IFreq_in  = 1'b0;
        IFaddr_in = $urandom;
        chk("hit_pulse", {31'd0, IFinstE_out}, {31'd0, hit});
        chk("miss_req", {31'd0, memReq_out}, {31'd0, !hit});
        if (!hit) begin
            hold_ok = 1'b1;
            n = 0;
            while (!IFinstE_out && n < 200) begin
                if (memReq_out !== 1'b1 || memAddr_out !== al || busy_out !== 1'b1) hold_ok = 1'b0;
                IFreq_in  = $urandom_range(0, 1);
                step();
                n++;
            end
            IFreq_in = 1'b0;
            chk("miss_timeout", {31'd0, IFinstE_out}, 32'd1);
            chk("miss_hold", {31'd0, hold_ok}, 32'd1);
            chk("fill_req_drop", {30'd0, memReq_out, busy_out}, 32'd0);
            mv[al[8:2]] = 1'b1;
            mt[al[8:2]] = al[31:9];
        end
    endtask

    initial begin
        rst_in    = 1'b1;
        IFreq_in  = 1'b0;
        IFaddr_in = '0;
        flush_in  = 1'b0;
        for (int i = 0; i < 128; i++) mv[i] = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_outputs", {IFinstE_out, busy_out, memReq_out, 29'd0}, 32'd0);
        chk("rst_inst", IFinst_out, 32'd0);
        chk("rst_addr", memAddr_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Cold miss with a 5-cycle memCtrl return, then a hit on the same word.
        mem_lat = 5;
        fetch(32'h0);
        fetch(32'h0);
        // Same index, different tag: both evict each other.
        fetch(32'h200);
        fetch(32'h0);

        // Flush two cycles into a miss, coinciding with returned data.
        resp_en = 1'b0;
        step();
        IFreq_in  = 1'b1;
        IFaddr_in = 32'h4;
        step();
        IFreq_in = 1'b0;
        chk("flush_miss_req", {31'd0, memReq_out}, 32'd1);
        step();
        flush_in = 1'b1;
        man_e    = 1'b1;
        man_data = 32'hDEADBEEF;
        step();
        flush_in = 1'b0;
        man_e    = 1'b0;
        chk("flush_drop", {29'd0, IFinstE_out, memReq_out, busy_out}, 32'd0);
        // Late data while idle must be ignored.
        man_e    = 1'b1;
        man_data = 32'hBADC0DE0;
        step();
        man_e = 1'b0;
        chk("idle_late_data", {31'd0, IFinstE_out}, 32'd0);
        resp_en = 1'b1;
        fetch(32'h4);

        // Warm 0x8, then three back-to-back hits.
        fetch(32'h8);
        exp_q.push_back(mem_word(32'h0));
        exp_q.push_back(mem_word(32'h4));
        exp_q.push_back(mem_word(32'h8));
        step();
        IFreq_in  = 1'b1;
        IFaddr_in = 32'h0;
        step();
        chk("burst_pulse0", {31'd0, IFinstE_out}, 32'd1);
        IFaddr_in = 32'h4;
        step();
        chk("burst_pulse1", {31'd0, IFinstE_out}, 32'd1);
        IFaddr_in = 32'h8;
        step();
        chk("burst_pulse2", {31'd0, IFinstE_out}, 32'd1);
        IFreq_in = 1'b0;
        step();
        chk("burst_end", {31'd0, IFinstE_out}, 32'd0);

        // Randomised fetches over a small aliased address set.
        for (int i = 0; i < 80; i++) begin
            mem_lat = $urandom_range(1, 6);
            fetch(({29'd0, 3'($urandom_range(0, 3))} << 9) |
                  ({27'd0, 5'($urandom_range(0, 7))} << 2) |
                  {30'd0, 2'($urandom_range(0, 3))});
        end

        // Asynchronous reset in the middle of a miss.
        resp_en = 1'b0;
        step();
        IFreq_in  = 1'b1;
        IFaddr_in = 32'h380;
        step();
        IFreq_in = 1'b0;
        chk("rstmiss_req", {31'd0, memReq_out}, 32'd1);
        step();
        step();
        #1;
        rst_in = 1'b1;
        #1;
        chk("async_rst_ctl", {29'd0, IFinstE_out, memReq_out, busy_out}, 32'd0);
        chk("async_rst_addr", memAddr_out, 32'd0);
        chk("async_rst_inst", IFinst_out, 32'd0);
        for (int i = 0; i < 128; i++) mv[i] = 1'b0;
        exp_q.delete();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in  = 1'b0;
        resp_en = 1'b1;
        mem_lat = 3;
        fetch(32'h8);
        fetch(32'h8);

        repeat (3) step();
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
